ex_mem_stage: RTL and testbench

- Execute-to-memory pipeline stage, directly downstream of the 64-bit ALU built from the 1-bit slices.
- Registers the ALU result and the memory/writeback control for the MEM stage.
- Computes N/Z/C/V from the ALU result and slice carries, and holds the architectural NZCV flag register used by B.cond.
- Supports pipeline stall (hold) and flush (bubble insertion).

---
 rtl/alu_pkg.sv | 20 ++
 rtl/ex_mem_stage_flag_unit.sv | 40 ++++
 rtl/ex_mem_stage.sv | 135 +++++++++++++
 tb/tb_ex_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encodings and the NZCV flag bundle used by
// the execute stage, the EX/MEM pipeline register and branch resolution.
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    // Packed so that {n,z,c,v} maps directly onto a 4-bit flag vector.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/ex_mem_stage_flag_unit.sv
// flag_unit: purely combinational N/Z/C/V generation from the 64-bit ALU
// result and the carries around the most significant 1-bit slice.
// Only ADD/SUB produce carry and overflow; logical ops, PASS_B and the
// unused codes 001/111 clear C and V.
module flag_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             cout_msb,
    input  logic             cin_msb,
    output nzcv_t            flags
);

    // Derive the flag bundle from the current ALU outputs.
    always_comb begin
        flags.n = alu_result[WIDTH-1];
        flags.z = ~|alu_result;
        flags.c = 1'b0;
        flags.v = 1'b0;
        case (alu_sel)
            ALU_ADD, ALU_SUB: begin
                flags.c = cout_msb;
                flags.v = cout_msb ^ cin_msb;
            end
            ALU_AND, ALU_OR, ALU_XOR, ALU_PASS_B: begin
                flags.c = 1'b0;
                flags.v = 1'b0;
            end
            default: begin
                // Unused encodings behave like PASS_B for flag purposes.
                flags.c = 1'b0;
                flags.v = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register plus the architectural NZCV flag
// register. Priority per cycle is reset > flush > stall > load.
// Optional feature macro: FLAG_FWD_EN -- when defined, nzcv_fwd bypasses the
// freshly computed flags of a flag-setting instruction in EX so a B.cond right
// behind it can resolve without a stall; otherwise nzcv_fwd is nzcv_o.
module ex_mem_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             cout_msb,
    input  logic             cin_msb,
    input  logic             set_flags,
    input  logic [REGW-1:0]  rd,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] store_data,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] store_data_o,
    output logic [REGW-1:0]  rd_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [3:0]       nzcv_o,
    output logic [3:0]       nzcv_fwd
);

    nzcv_t            flags_s;
    logic             load_s;
    logic             flag_upd_s;

    logic             valid_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] store_data_r;
    logic [REGW-1:0]  rd_r;
    logic             reg_write_r;
    logic             mem_read_r;
    logic             mem_write_r;
    nzcv_t            nzcv_r;

    flag_unit #(
        .WIDTH (WIDTH)
    ) u_flag_unit (
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .cout_msb   (cout_msb),
        .cin_msb    (cin_msb),
        .flags      (flags_s)
    );

    assign load_s     = ~flush & ~stall;
    assign flag_upd_s = load_s & in_valid & set_flags;

    // Valid and control bits: cleared by reset and flush, held by stall,
    // otherwise qualified by in_valid so a non-instruction never writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else if (flush) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else if (stall) begin
            valid_r     <= valid_r;
            reg_write_r <= reg_write_r;
            mem_read_r  <= mem_read_r;
            mem_write_r <= mem_write_r;
        end else begin
            valid_r     <= in_valid;
            reg_write_r <= reg_write & in_valid;
            mem_read_r  <= mem_read  & in_valid;
            mem_write_r <= mem_write & in_valid;
        end
    end

    // Data fields: only reset clears them; a bubble leaves them untouched
    // since valid_o already marks them as meaningless.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r     <= {WIDTH{1'b0}};
            store_data_r <= {WIDTH{1'b0}};
            rd_r         <= {REGW{1'b0}};
        end else if (load_s) begin
            result_r     <= alu_result;
            store_data_r <= store_data;
            rd_r         <= rd;
        end else begin
            result_r     <= result_r;
            store_data_r <= store_data_r;
            rd_r         <= rd_r;
        end
    end

    // Architectural flags: only a real, loaded, flag-setting instruction
    // may change them.
    always_ff @(posedge clk) begin
        if (reset) begin
            nzcv_r <= 4'b0000;
        end else if (flag_upd_s) begin
            nzcv_r <= flags_s;
        end else begin
            nzcv_r <= nzcv_r;
        end
    end

    assign valid_o      = valid_r;
    assign result_o     = result_r;
    assign store_data_o = store_data_r;
    assign rd_o         = rd_r;
    assign reg_write_o  = reg_write_r;
    assign mem_read_o   = mem_read_r;
    assign mem_write_o  = mem_write_r;
    assign nzcv_o       = nzcv_r;

`ifdef FLAG_FWD_EN
    assign nzcv_fwd = (in_valid & set_flags & ~flush) ? flags_s : nzcv_r;
`else
    assign nzcv_fwd = nzcv_r;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a reference model predicts the stage
// state for every clock edge; predictions are queued when stimulus is driven
// and popped and compared once the edge has produced the DUT output.
module tb_ex_mem_stage;

    localparam int WIDTH = 64;
    localparam int REGW  = 5;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] sdata;
        logic [REGW-1:0]  rd;
        logic             rw;
        logic             mr;
        logic             mw;
        logic [3:0]       nzcv;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset, stall, flush, in_valid;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_result, store_data;
    logic             cout_msb, cin_msb, set_flags;
    logic [REGW-1:0]  rd;
    logic             reg_write, mem_read, mem_write;
    logic             valid_o;
    logic [WIDTH-1:0] result_o, store_data_o;
    logic [REGW-1:0]  rd_o;
    logic             reg_write_o, mem_read_o, mem_write_o;
    logic [3:0]       nzcv_o, nzcv_fwd;

    exp_t sb[$];
    exp_t m;
    exp_t e;
    exp_t o;
    int   n_cmp  = 0;
    int   n_fail = 0;

    ex_mem_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .alu_sel(alu_sel), .alu_result(alu_result),
        .cout_msb(cout_msb), .cin_msb(cin_msb), .set_flags(set_flags),
        .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .store_data(store_data),
        .valid_o(valid_o), .result_o(result_o), .store_data_o(store_data_o),
        .rd_o(rd_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .nzcv_o(nzcv_o), .nzcv_fwd(nzcv_fwd)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_flags(input logic [2:0] sel,
                                             input logic [WIDTH-1:0] res,
                                             input logic co, input logic ci);
        logic n, z, c, v;
        n = res[WIDTH-1];
        z = (res == 64'd0);
        c = 1'b0;
        v = 1'b0;
        if (sel == 3'b010 || sel == 3'b011) begin
            c = co;
            v = co ^ ci;
        end
        return {n, z, c, v};
    endfunction

    function automatic exp_t model_next(input exp_t cur);
        exp_t nx;
        nx = cur;
        if (reset) begin
            nx = '0;
        end else if (flush) begin
            nx.valid = 1'b0;
            nx.rw    = 1'b0;
            nx.mr    = 1'b0;
            nx.mw    = 1'b0;
        end else if (!stall) begin
            nx.valid  = in_valid;
            nx.result = alu_result;
            nx.sdata  = store_data;
            nx.rd     = rd;
            nx.rw     = reg_write & in_valid;
            nx.mr     = mem_read & in_valid;
            nx.mw     = mem_write & in_valid;
            if (in_valid && set_flags)
                nx.nzcv = ref_flags(alu_sel, alu_result, cout_msb, cin_msb);
        end
        return nx;
    endfunction

    function automatic logic [3:0] exp_fwd();
`ifdef FLAG_FWD_EN
        if (in_valid && set_flags && !flush)
            return ref_flags(alu_sel, alu_result, cout_msb, cin_msb);
        return m.nzcv;
`else
        return m.nzcv;
`endif
    endfunction

    function automatic exp_t observe();
        exp_t ob;
        ob = {valid_o, result_o, store_data_o, rd_o,
              reg_write_o, mem_read_o, mem_write_o, nzcv_o};
        return ob;
    endfunction

    // Predict the next state, queue it, and let the edge happen.
    task automatic apply();
        m = model_next(m);
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic iv, input logic [2:0] sel,
                          input logic [WIDTH-1:0] res, input logic co,
                          input logic ci, input logic sf);
        in_valid   = iv;
        alu_sel    = sel;
        alu_result = res;
        cout_msb   = co;
        cin_msb    = ci;
        set_flags  = sf;
    endtask

    task automatic randomize_inputs();
        in_valid   = 1'($urandom);
        alu_sel    = 3'($urandom);
        alu_result = {32'($urandom), 32'($urandom)};
        if ($urandom_range(0, 3) == 0) alu_result = 64'd0;
        cout_msb   = 1'($urandom);
        cin_msb    = 1'($urandom);
        set_flags  = 1'($urandom);
        rd         = 5'($urandom);
        reg_write  = 1'($urandom);
        mem_read   = 1'($urandom);
        mem_write  = 1'($urandom);
        store_data = {32'($urandom), 32'($urandom)};
    endtask

    task automatic test_reset();
        randomize_inputs();
        reset = 1'b1; stall = 1'b1; flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL reset_state got %h want %h", o, e);
            end
            randomize_inputs();
        end
        n_cmp++;
        if (nzcv_o !== 4'b0000 || valid_o !== 1'b0 || result_o !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_zero got nzcv=%b valid=%b result=%h want 0", nzcv_o, valid_o, result_o);
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_subs_eq();
        set_op(1'b1, 3'b011, 64'd0, 1'b1, 1'b1, 1'b1);
        rd = 5'd3; reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        store_data = 64'h1234;
        #1;
        n_cmp++;
        if (nzcv_fwd !== exp_fwd()) begin
            n_fail++; $display("FAIL subs_fwd got %b want %b", nzcv_fwd, exp_fwd());
        end
        apply();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL subs_state got %h want %h", o, e);
        end
        n_cmp++;
        if (nzcv_o !== 4'b0110 || result_o !== 64'd0 || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL subs_flags got nzcv=%b result=%h valid=%b want 0110/0/1", nzcv_o, result_o, valid_o);
        end
    endtask

    task automatic test_adds_ovf();
        set_op(1'b1, 3'b010, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        apply();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e || nzcv_o !== 4'b1001) begin
            n_fail++; $display("FAIL adds_ovf got nzcv=%b want 1001 (state %h vs %h)", nzcv_o, o, e);
        end
        // ANDS with stray carries: C and V must still clear.
        set_op(1'b1, 3'b100, 64'd5, 1'b1, 1'b0, 1'b1);
        apply();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e || nzcv_o !== 4'b0000) begin
            n_fail++; $display("FAIL ands_clear got nzcv=%b want 0000 (state %h vs %h)", nzcv_o, o, e);
        end
    endtask

    task automatic test_stall_flush();
        logic [3:0] saved;
        set_op(1'b1, 3'b010, 64'h10, 1'b1, 1'b0, 1'b1);
        rd = 5'd7; reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        apply();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL load_rd7 got %h want %h", o, e);
        end
        saved = nzcv_o;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            in_valid = 1'b1; set_flags = 1'b1; stall = 1'b1;
            apply();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e || rd_o !== 5'd7 || nzcv_o !== saved) begin
                n_fail++; $display("FAIL stall_hold got %h want %h", o, e);
            end
        end
        randomize_inputs();
        in_valid = 1'b1; set_flags = 1'b1; flush = 1'b1; stall = 1'b1;
        apply();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e || valid_o !== 1'b0 || reg_write_o !== 1'b0 ||
            rd_o !== 5'd7 || nzcv_o !== saved) begin
            n_fail++;
            $display("FAIL flush_stall got valid=%b rw=%b rd=%0d nzcv=%b want 0/0/7/%b", valid_o, reg_write_o, rd_o, nzcv_o, saved);
        end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_bubble();
        logic [3:0] saved;
        saved = nzcv_o;
        set_op(1'b0, 3'b011, 64'd0, 1'b1, 1'b1, 1'b1);
        mem_write = 1'b1; reg_write = 1'b1; mem_read = 1'b1;
        apply();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e || mem_write_o !== 1'b0 || nzcv_o !== saved) begin
            n_fail++; $display("FAIL bubble got mw=%b nzcv=%b want 0/%b", mem_write_o, nzcv_o, saved);
        end
        set_op(1'b1, 3'b010, 64'd0, 1'b1, 1'b1, 1'b0);
        mem_write = 1'b0;
        apply();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e || nzcv_o !== saved) begin
            n_fail++; $display("FAIL add_noflags got nzcv=%b want %b", nzcv_o, saved);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_op(1'b1, 3'b011, 64'hFFFF_0000_0000_0001, 1'b1, 1'b0, 1'b1);
        apply();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin
            n_fail++; $display("FAIL pre_reset_load got %h want %h", o, e);
        end
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        apply();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e || o !== exp_t'(0)) begin
            n_fail++; $display("FAIL reset_mid_stall got %h want 0", o);
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            randomize_inputs();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            if (i % 2 == 0) begin
                in_valid = 1'b1; set_flags = 1'b1; stall = 1'b0; flush = 1'b0;
            end
            #1;
            n_cmp++;
            if (nzcv_fwd !== exp_fwd()) begin
                n_fail++; $display("FAIL rand_fwd[%0d] got %b want %b", i, nzcv_fwd, exp_fwd());
            end
            apply();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL rand_state[%0d] got %h want %h", i, o, e);
            end
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        m = '0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_op(1'b0, 3'b000, 64'd0, 1'b0, 1'b0, 1'b0);
        rd = 5'd0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        store_data = 64'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_subs_eq();
        test_adds_ovf();
        test_stall_flush();
        test_bubble();
        test_reset_mid_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
